rr_queue_scheduler: RTL
=======================

# rr_queue_scheduler

Sequential round-robin dequeue scheduler for the packet-scheduling path. Each cycle it can evaluate the per-queue non-empty flags, pick the next eligible queue after the last-served one (wrapping), and issue a registered grant over a valid/ready handshake. It grants up to `QUANTUM` packets per queue turn before moving on. It owns the round-robin pointer: the consumer side of the next-valid search, holding the current selection, advancing it and presenting it downstream.

## Interface
Parameters:
- `QUEUE_COUNT`, 3: number of queues; must be ≥ 2.
- `SEL_WIDTH`, `$clog2(QUEUE_COUNT)`: queue index width.
- `QUANTUM`, 2: maximum grants per queue turn; must be ≥ 1.
- `CNT_WIDTH`, `$clog2(QUANTUM+1)`: burst counter width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new grants; never cancels an outstanding grant.
- `queue_valid`  in  `QUEUE_COUNT`  bit i = queue i non-empty; updated by the dequeue side the cycle after an accept.
- `grant_valid`  out  1  grant offered.
- `grant_ready`  in  1  downstream accepts the grant (dequeues one packet).
- `grant_index`  out  `SEL_WIDTH`  granted queue.
- `grant_last`  out  1  this grant ends the queue's turn (burst count reaches `QUANTUM`).
- `curr_ptr`  out  `SEL_WIDTH`  last-served queue (status).

## Operation
- Reset values:
  - state IDLE
  - `grant_valid`=0, `grant_index`=0, `grant_last`=0
  - `curr_ptr`=`QUEUE_COUNT-1`, so queue 0 has first priority
  - `burst_cnt`=0
- Round-robin search from `curr_ptr`: the lowest-index valid queue strictly above `curr_ptr`. Otherwise, the lowest-index valid queue at or below `curr_ptr`. `curr_ptr` itself is eligible, but last.
- IDLE: if `enable` and any `queue_valid` bit is set, select a queue and load `grant_index`, set `grant_valid`=1, then go to GRANT. Otherwise stay in IDLE.
  - Continue burst: if `burst_cnt`≠0 and `queue_valid[curr_ptr]`=1, select `curr_ptr` and keep `burst_cnt`.
  - Otherwise: select the round-robin search result and clear `burst_cnt` to 0.
- GRANT: `grant_valid`=1, and `grant_index`/`grant_last` stay stable until accepted.
  - A drop of `queue_valid` or `enable` does not retract the grant.
  - On `grant_valid & grant_ready`:
    - `curr_ptr` ← `grant_index`.
    - `burst_cnt` ← `burst_cnt+1`, or 0 if `burst_cnt+1`==`QUANTUM`.
    - `grant_valid` ← 0, then go to SETTLE.
- SETTLE: one-cycle bubble so `queue_valid` reflects the dequeue, then go to IDLE.
- `grant_last` = `grant_valid` & (`burst_cnt`==`QUANTUM-1`), registered with the grant.
- Queue empties mid-burst: the next IDLE evaluation sees `queue_valid[curr_ptr]`=0. It switches via search, and the count restarts.
- Only one queue valid: after its turn ends, the search wraps to the same queue and a new turn starts. Grants continue without starvation.
- `QUANTUM`=1: every grant has `grant_last`=1 and the pointer advances on every accept.

## Timing
- Decision latency: `queue_valid`/`enable` sampled in IDLE at cycle N → `grant_valid`=1 at cycle N+1.
- Accept at edge M:
  - `grant_valid`=0 during M+1 (SETTLE).
  - IDLE evaluates at M+2.
  - The next grant is visible at M+3.
  - Minimum grant-to-grant spacing is 3 cycles.
- `grant_ready` has no effect while `grant_valid`=0.
- `rst_n` low at any point, including mid-GRANT: all outputs and state return to their reset values immediately (asynchronously). The first grant comes no earlier than 1 cycle after the first IDLE evaluation following reset release.
- All arithmetic is unsigned. The pointer wraps modulo `QUEUE_COUNT`; no index ≥ `QUEUE_COUNT` is ever produced.

## Test plan
(`QUEUE_COUNT`=3, `QUANTUM`=2)
- Reset, `queue_valid`=3'b111, `enable`=1, `grant_ready`=1 → `grant_index` sequence 0,0,1,1,2,2,0…; `grant_last`=1 on every second grant; one grant every 3 cycles.
- `queue_valid`=3'b100 only → grants 2,2,2,2…; `grant_last` alternates 0,1; `curr_ptr`=2 throughout.
- First grant to queue 0 pending, `grant_ready`=0 for 5 cycles, and `queue_valid` forced to 0 meanwhile → `grant_valid` held at 1, `grant_index`=0 stable; accept on the 6th cycle → SETTLE, then no new grant.
- `queue_valid`=3'b011: grant q0 accepted, then bit0 cleared before the next IDLE evaluation → next grant is q1 with `grant_last`=0, followed by q1 with `grant_last`=1.
- `enable`=0 with `queue_valid`=3'b010 → no grant; `enable`→1 at cycle N → grant q1 at N+1.
- `rst_n` pulsed low while a grant to q1 is pending → `grant_valid` drops immediately and `curr_ptr`=2; after release with `queue_valid`=3'b111 the first grant is q0.

Source files
------------

// File: rtl/rr_queue_scheduler.sv
// Round-robin dequeue scheduler: picks the next non-empty queue after the last-served one
// and offers a registered grant over valid/ready, serving up to QUANTUM packets per turn.
module rr_queue_scheduler #(
   parameter int QUEUE_COUNT = 3,
   parameter int SEL_WIDTH   = $clog2(QUEUE_COUNT),
   parameter int QUANTUM     = 2,
   parameter int CNT_WIDTH   = $clog2(QUANTUM + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [QUEUE_COUNT-1:0] queue_valid,
   output logic                   grant_valid,
   input  logic                   grant_ready,
   output logic [SEL_WIDTH-1:0]   grant_index,
   output logic                   grant_last,
   output logic [SEL_WIDTH-1:0]   curr_ptr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t                 state;
   logic [CNT_WIDTH-1:0]   burst_cnt;
   logic [CNT_WIDTH-1:0]   burst_inc;
   logic [CNT_WIDTH-1:0]   cnt_sel;
   logic [QUEUE_COUNT-1:0] above_mask;
   logic [SEL_WIDTH-1:0]   search_idx;
   logic [SEL_WIDTH-1:0]   sel_idx;
   logic                   continue_burst;

   // Queues strictly above the last-served one get first pick in the rotation.
   generate
      for (genvar gi = 0; gi < QUEUE_COUNT; gi++) begin : g_above
         assign above_mask[gi] = queue_valid[gi] && (SEL_WIDTH'(gi) > curr_ptr);
      end
   endgenerate

   function automatic logic [SEL_WIDTH-1:0] lowest_set(input logic [QUEUE_COUNT-1:0] mask);
      logic [SEL_WIDTH-1:0] res;
      res = '0;
      for (int i = QUEUE_COUNT - 1; i >= 0; i--) begin
         if (mask[i]) res = SEL_WIDTH'(i);
      end
      return res;
   endfunction

   always_comb begin
      burst_inc      = burst_cnt + CNT_WIDTH'(1);
      continue_burst = (burst_cnt != '0) && queue_valid[curr_ptr];
      // With nothing above the pointer, the lowest valid queue overall wraps around,
      // leaving curr_ptr itself as the last candidate.
      search_idx     = (|above_mask) ? lowest_set(above_mask) : lowest_set(queue_valid);
      sel_idx        = continue_burst ? curr_ptr : search_idx;
      cnt_sel        = continue_burst ? burst_cnt : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         grant_valid <= 1'b0;
         grant_index <= '0;
         grant_last  <= 1'b0;
         curr_ptr    <= SEL_WIDTH'(QUEUE_COUNT - 1);
         burst_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable && (|queue_valid)) begin
                  grant_index <= sel_idx;
                  grant_last  <= (cnt_sel == CNT_WIDTH'(QUANTUM - 1));
                  burst_cnt   <= cnt_sel;
                  grant_valid <= 1'b1;
                  state       <= GRANT;
               end
            end
            GRANT: begin
               if (grant_ready) begin
                  curr_ptr    <= grant_index;
                  burst_cnt   <= (burst_inc == CNT_WIDTH'(QUANTUM)) ? '0 : burst_inc;
                  grant_valid <= 1'b0;
                  grant_last  <= 1'b0;
                  state       <= SETTLE;
               end
            end
            // Bubble so queue_valid reflects the dequeue before the next decision.
            SETTLE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
